// File: rtl/qbus_dl11_if.sv
// QBUS slave-side signal bundle for the DL11 console unit.
// All strobes are active-low, as they appear on the backplane.
interface qbus_dl11_if;
  logic [15:0] pin_ad_n;
  logic [15:0] ad_out_n;
  logic        ad_oe;
  logic        pin_sync_n;
  logic        pin_din_n;
  logic        pin_dout_n;
  logic        pin_wtbt_n;
  logic        pin_iako_n;
  logic        pin_rply_n;
  logic        pin_virq_n;

  modport slave (
    input  pin_ad_n, pin_sync_n, pin_din_n, pin_dout_n, pin_wtbt_n, pin_iako_n,
    output ad_out_n, ad_oe, pin_rply_n, pin_virq_n
  );

  modport master (
    output pin_ad_n, pin_sync_n, pin_din_n, pin_dout_n, pin_wtbt_n, pin_iako_n,
    input  ad_out_n, ad_oe, pin_rply_n, pin_virq_n
  );
endinterface

// File: rtl/qbus_dl11.sv
// DL11 console serial line unit: QBUS register slave (RCSR/RBUF/XCSR/XBUF),
// vectored RX/TX interrupts and an 8N1 UART.
module qbus_dl11 #(
  parameter logic [15:0] BASE     = 16'o177560,
  parameter logic [15:0] VEC_RX   = 16'o000060,
  parameter logic [15:0] VEC_TX   = 16'o000064,
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic        pin_clk,
  input  logic        pin_init_n,
  qbus_dl11_if.slave  bus,
  output logic        txd,
  input  logic        rxd
);

  localparam logic [15:0] BIT_END  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_END = 16'(BAUD_DIV / 2 - 1);

  typedef enum logic [2:0] {B_IDLE, B_RD, B_WR, B_VEC, B_ACK} bus_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BRK} rx_state_t;

  // synchronisers
  logic sync_s1, sync_s2, sync_s3;
  logic din_s1, din_s2, dout_s1, dout_s2, iako_s1, iako_s2, rxd_s1, rxd_s2;

  // address phase
  logic       sel, byte_wr;
  logic [2:0] addr_lo;

  // bus FSM and registers
  bus_state_t  bstate;
  logic [7:0]  wdata;
  logic        rbuf_rd;
  logic        rx_ie, tx_ie, rx_done, tx_rdy, rx_err, rx_ovr;
  logic [7:0]  rbuf;
  logic        rx_req, tx_req, rx_cond_d, tx_cond_d;
  logic        rx_cond, tx_cond;
  logic [15:0] rdata;
  logic        tx_load;
  logic [7:0]  tx_data;

  // transmitter
  tx_state_t   tstate;
  logic [15:0] tcnt;
  logic [2:0]  tbit;
  logic [7:0]  tsh;
  logic        tx_fin;

  // receiver
  rx_state_t   rstate;
  logic [15:0] rcnt;
  logic [2:0]  rbit;
  logic [7:0]  rsh;
  logic        rx_load, rx_stop;

  assign rx_cond        = rx_done & rx_ie;
  assign tx_cond        = tx_rdy & tx_ie;
  assign bus.pin_virq_n = ~(rx_req | tx_req);

  // Two-stage synchronisers for async strobes and serial input; idle level is 1.
  always_ff @(posedge pin_clk or negedge pin_init_n) begin
    if (!pin_init_n) begin
      sync_s1 <= 1'b1; sync_s2 <= 1'b1; sync_s3 <= 1'b1;
      din_s1  <= 1'b1; din_s2  <= 1'b1;
      dout_s1 <= 1'b1; dout_s2 <= 1'b1;
      iako_s1 <= 1'b1; iako_s2 <= 1'b1;
      rxd_s1  <= 1'b1; rxd_s2  <= 1'b1;
    end else begin
      sync_s1 <= bus.pin_sync_n; sync_s2 <= sync_s1; sync_s3 <= sync_s2;
      din_s1  <= bus.pin_din_n;  din_s2  <= din_s1;
      dout_s1 <= bus.pin_dout_n; dout_s2 <= dout_s1;
      iako_s1 <= bus.pin_iako_n; iako_s2 <= iako_s1;
      rxd_s1  <= rxd;            rxd_s2  <= rxd_s1;
    end
  end

  // Latch address/byte status on SYNC assertion, drop selection on SYNC release.
  always_ff @(posedge pin_clk or negedge pin_init_n) begin
    if (!pin_init_n) begin
      sel     <= 1'b0;
      byte_wr <= 1'b0;
      addr_lo <= '0;
    end else if (sync_s3 && !sync_s2) begin
      sel     <= (~bus.pin_ad_n[15:3] == BASE[15:3]);
      byte_wr <= ~bus.pin_wtbt_n;
      addr_lo <= ~bus.pin_ad_n[2:0];
    end else if (!sync_s3 && sync_s2) begin
      sel <= 1'b0;
    end
  end

  // Register read multiplexer; unused bits read as zero.
  always_comb begin
    rdata = '0;
    case (addr_lo[2:1])
      2'd0:    rdata = {8'h00, rx_done, rx_ie, 6'b0};
      2'd1:    rdata = {rx_err, rx_ovr, 6'b0, rbuf};
      2'd2:    rdata = {8'h00, tx_rdy, tx_ie, 6'b0};
      default: rdata = '0;
    endcase
  end

  // Bus cycle FSM, CSR/buffer registers and interrupt request tracking.
  always_ff @(posedge pin_clk or negedge pin_init_n) begin
    if (!pin_init_n) begin
      bstate         <= B_IDLE;
      bus.ad_oe      <= 1'b0;
      bus.ad_out_n   <= '1;
      bus.pin_rply_n <= 1'b1;
      wdata          <= '0;
      rbuf_rd        <= 1'b0;
      rx_ie          <= 1'b0;
      tx_ie          <= 1'b0;
      rx_done        <= 1'b0;
      tx_rdy         <= 1'b1;
      rx_err         <= 1'b0;
      rx_ovr         <= 1'b0;
      rbuf           <= '0;
      rx_req         <= 1'b0;
      tx_req         <= 1'b0;
      rx_cond_d      <= 1'b0;
      tx_cond_d      <= 1'b0;
      tx_load        <= 1'b0;
      tx_data        <= '0;
    end else begin
      tx_load   <= 1'b0;
      rx_cond_d <= rx_cond;
      tx_cond_d <= tx_cond;
      if (!rx_cond)       rx_req <= 1'b0;
      else if (!rx_cond_d) rx_req <= 1'b1;
      if (!tx_cond)       tx_req <= 1'b0;
      else if (!tx_cond_d) tx_req <= 1'b1;

      case (bstate)
        B_IDLE: begin
          if (!iako_s2 && !din_s2 && (rx_req || tx_req)) begin
            bstate         <= B_VEC;
            bus.pin_rply_n <= 1'b0;
            bus.ad_oe      <= 1'b1;
            if (rx_req) begin
              bus.ad_out_n <= ~VEC_RX;
              rx_req       <= 1'b0;
            end else begin
              bus.ad_out_n <= ~VEC_TX;
              tx_req       <= 1'b0;
            end
          end else if (sel && !din_s2) begin
            bstate         <= B_RD;
            bus.pin_rply_n <= 1'b0;
            bus.ad_oe      <= 1'b1;
            bus.ad_out_n   <= ~rdata;
            rbuf_rd        <= (addr_lo[2:1] == 2'd1);
          end else if (sel && !dout_s2) begin
            bstate         <= B_WR;
            bus.pin_rply_n <= 1'b0;
            wdata          <= ~bus.pin_ad_n[7:0];
          end
        end
        B_RD, B_VEC: bstate <= B_ACK;
        B_WR: begin
          bstate <= B_ACK;
          if (!(byte_wr && addr_lo[0])) begin
            case (addr_lo[2:1])
              2'd0: rx_ie <= wdata[6];
              2'd2: tx_ie <= wdata[6];
              2'd3: if (tx_rdy) begin
                tx_data <= wdata;
                tx_load <= 1'b1;
                tx_rdy  <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        B_ACK: begin
          if (din_s2 && dout_s2) begin
            bstate         <= B_IDLE;
            bus.pin_rply_n <= 1'b1;
            bus.ad_oe      <= 1'b0;
            bus.ad_out_n   <= '1;
            rbuf_rd        <= 1'b0;
            if (rbuf_rd) begin
              rx_done <= 1'b0;
              rx_err  <= 1'b0;
              rx_ovr  <= 1'b0;
            end
          end
        end
        default: bstate <= B_IDLE;
      endcase

      // UART events come last so they override a same-cycle bus update.
      if (tx_fin) tx_rdy <= 1'b1;
      if (rx_load) begin
        rbuf    <= rsh;
        rx_done <= 1'b1;
        rx_err  <= ~rx_stop;
        rx_ovr  <= rx_done;
      end
    end
  end

  // Transmitter: start bit, 8 data bits LSB first, stop bit, BAUD_DIV clocks each.
  always_ff @(posedge pin_clk or negedge pin_init_n) begin
    if (!pin_init_n) begin
      tstate <= T_IDLE;
      tcnt   <= '0;
      tbit   <= '0;
      tsh    <= '0;
      txd    <= 1'b1;
      tx_fin <= 1'b0;
    end else begin
      tx_fin <= 1'b0;
      case (tstate)
        T_IDLE: if (tx_load) begin
          tsh    <= tx_data;
          tcnt   <= '0;
          txd    <= 1'b0;
          tstate <= T_START;
        end
        T_START: if (tcnt == BIT_END) begin
          tcnt   <= '0;
          tbit   <= '0;
          txd    <= tsh[0];
          tstate <= T_DATA;
        end else tcnt <= tcnt + 16'd1;
        T_DATA: if (tcnt == BIT_END) begin
          tcnt <= '0;
          if (tbit == 3'd7) begin
            txd    <= 1'b1;
            tstate <= T_STOP;
          end else begin
            tbit <= tbit + 3'd1;
            tsh  <= tsh >> 1;
            txd  <= tsh[1];
          end
        end else tcnt <= tcnt + 16'd1;
        T_STOP: if (tcnt == BIT_END) begin
          tcnt   <= '0;
          tx_fin <= 1'b1;
          tstate <= T_IDLE;
        end else tcnt <= tcnt + 16'd1;
        default: tstate <= T_IDLE;
      endcase
    end
  end

  // Receiver: validate start at half bit, then sample mid-bit every BAUD_DIV.
  // A low stop bit parks in R_BRK until the line returns high, so the tail of
  // a framing error is never mistaken for a new start bit.
  always_ff @(posedge pin_clk or negedge pin_init_n) begin
    if (!pin_init_n) begin
      rstate  <= R_IDLE;
      rcnt    <= '0;
      rbit    <= '0;
      rsh     <= '0;
      rx_load <= 1'b0;
      rx_stop <= 1'b1;
    end else begin
      rx_load <= 1'b0;
      case (rstate)
        R_IDLE: if (!rxd_s2) begin
          rcnt   <= '0;
          rstate <= R_START;
        end
        R_START: if (rcnt == HALF_END) begin
          rcnt   <= '0;
          rbit   <= '0;
          rstate <= rxd_s2 ? R_IDLE : R_DATA;
        end else rcnt <= rcnt + 16'd1;
        R_DATA: if (rcnt == BIT_END) begin
          rcnt <= '0;
          rsh  <= {rxd_s2, rsh[7:1]};
          if (rbit == 3'd7) rstate <= R_STOP;
          else              rbit   <= rbit + 3'd1;
        end else rcnt <= rcnt + 16'd1;
        R_STOP: if (rcnt == BIT_END) begin
          rcnt    <= '0;
          rx_load <= 1'b1;
          rx_stop <= rxd_s2;
          rstate  <= rxd_s2 ? R_IDLE : R_BRK;
        end else rcnt <= rcnt + 16'd1;
        R_BRK: if (rxd_s2) rstate <= R_IDLE;
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule
